// File: rtl/flood_reveal_ctrl.sv
// Open/flag command sequencer for the mine board and its cover.
// A zero-count open floods connected zero regions via a FIFO and a visited bitmap.
module flood_reveal_ctrl #(
  parameter int unsigned X_BITS = 4,
  parameter int unsigned Y_BITS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_flag_i,
  input  logic [X_BITS-1:0]      cmd_x_i,
  input  logic [Y_BITS-1:0]      cmd_y_i,
  output logic [X_BITS-1:0]      cell_x_o,
  output logic [Y_BITS-1:0]      cell_y_o,
  input  logic [4:0]             board_val_i,
  input  logic [1:0]             cover_val_i,
  output logic                   cover_open_o,
  output logic                   cover_flag_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   game_over_o,
  output logic [X_BITS+Y_BITS:0] revealed_count_o
);

  localparam int unsigned AW    = X_BITS + Y_BITS;
  localparam int unsigned Cells = 1 << AW;
  localparam logic [X_BITS-1:0] XOne = 1;
  localparam logic [Y_BITS-1:0] YOne = 1;
  localparam logic [X_BITS-1:0] XMax = '1;
  localparam logic [Y_BITS-1:0] YMax = '1;

  typedef enum logic [2:0] {
    StIdle, StCheck, StDecide, StPush, StPop, StFcheck, StFdecide
  } state_e;

  state_e            state_q;
  logic [X_BITS-1:0] cur_x_q;
  logic [Y_BITS-1:0] cur_y_q;
  logic [2:0]        k_q;
  logic [Cells-1:0]  visited_q;
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              game_over_q;
  logic [AW:0]       revealed_q;
  logic [AW-1:0]     fifo_mem [Cells];

  logic              covered, open_hit, mine_hit, fifo_empty, accept;
  logic              x_dec, x_inc, y_dec, y_inc, nb_in, push_en;
  logic [X_BITS-1:0] nb_x;
  logic [Y_BITS-1:0] nb_y;
  logic [AW-1:0]     nb_idx, cmd_idx;

  assign covered    = (cover_val_i == 2'b00);
  assign open_hit   = (state_q == StDecide) && covered;
  assign mine_hit   = open_hit && board_val_i[4];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign cmd_idx    = {cmd_y_i, cmd_x_i};
  assign accept     = cmd_valid_i && cmd_ready_o;

  // Neighbor k in raster order around the current cell, rejected at the board edge.
  always_comb begin
    x_dec = 1'b0;
    x_inc = 1'b0;
    y_dec = 1'b0;
    y_inc = 1'b0;
    unique case (k_q)
      3'd0: begin x_dec = 1'b1; y_dec = 1'b1; end
      3'd1: y_dec = 1'b1;
      3'd2: begin x_inc = 1'b1; y_dec = 1'b1; end
      3'd3: x_dec = 1'b1;
      3'd4: x_inc = 1'b1;
      3'd5: begin x_dec = 1'b1; y_inc = 1'b1; end
      3'd6: y_inc = 1'b1;
      3'd7: begin x_inc = 1'b1; y_inc = 1'b1; end
      default: ;
    endcase
    nb_x = cur_x_q;
    nb_y = cur_y_q;
    if (x_dec) nb_x = cur_x_q - XOne;
    else if (x_inc) nb_x = cur_x_q + XOne;
    if (y_dec) nb_y = cur_y_q - YOne;
    else if (y_inc) nb_y = cur_y_q + YOne;
    nb_in = !((x_dec && cur_x_q == '0) || (x_inc && cur_x_q == XMax) ||
              (y_dec && cur_y_q == '0) || (y_inc && cur_y_q == YMax));
  end

  assign nb_idx  = {nb_y, nb_x};
  assign push_en = (state_q == StPush) && nb_in && !visited_q[nb_idx];

  always_ff @(posedge clk_i) begin
    if (push_en) fifo_mem[wr_ptr_q[AW-1:0]] <= nb_idx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      k_q         <= '0;
      visited_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      game_over_q <= 1'b0;
      revealed_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cur_x_q            <= cmd_x_i;
            cur_y_q            <= cmd_y_i;
            visited_q          <= '0;
            visited_q[cmd_idx] <= 1'b1;
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            state_q            <= cmd_flag_i ? StFcheck : StCheck;
          end
        end
        StCheck: state_q <= StDecide;
        StDecide: begin
          if (!covered) begin
            state_q <= StPop;
          end else begin
            revealed_q <= revealed_q + 1'b1;
            if (board_val_i[4]) begin
              game_over_q <= 1'b1;
              rd_ptr_q    <= wr_ptr_q;
              state_q     <= StIdle;
            end else if (board_val_i[3:0] == 4'd0) begin
              k_q     <= '0;
              state_q <= StPush;
            end else begin
              state_q <= StPop;
            end
          end
        end
        StPush: begin
          if (push_en) begin
            wr_ptr_q          <= wr_ptr_q + 1'b1;
            visited_q[nb_idx] <= 1'b1;
          end
          k_q <= k_q + 1'b1;
          if (k_q == 3'd7) state_q <= StPop;
        end
        StPop: begin
          if (fifo_empty) begin
            state_q <= StIdle;
          end else begin
            {cur_y_q, cur_x_q} <= fifo_mem[rd_ptr_q[AW-1:0]];
            rd_ptr_q           <= rd_ptr_q + 1'b1;
            state_q            <= StCheck;
          end
        end
        StFcheck:  state_q <= StFdecide;
        StFdecide: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o      = (state_q == StIdle) && !game_over_q;
  assign busy_o           = (state_q != StIdle);
  assign cell_x_o         = cur_x_q;
  assign cell_y_o         = cur_y_q;
  assign cover_open_o     = open_hit;
  assign cover_flag_o     = (state_q == StFdecide) && !cover_val_i[1];
  assign done_o           = mine_hit || ((state_q == StPop) && fifo_empty) ||
                            (state_q == StFdecide);
  assign game_over_o      = game_over_q || mine_hit;
  assign revealed_count_o = revealed_q;

endmodule

// File: tb/tb_flood_reveal_ctrl.sv
// Directed bench for flood_reveal_ctrl with a registered-read board/cover model.
module tb_flood_reveal_ctrl;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready, cmd_flag;
  logic [3:0] cmd_x, cmd_y, cell_x, cell_y;
  logic [4:0] board_val;
  logic [1:0] cover_val;
  logic       cover_open, cover_flag, busy, done, game_over;
  logic [8:0] revealed;
  logic       cov_clr;
  logic [7:0] idx;

  logic [4:0] board_mem [256];
  logic [1:0] cover_mem [256];
  int n_tests = 0;
  int n_fail  = 0;

  flood_reveal_ctrl #(.X_BITS(4), .Y_BITS(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_flag_i(cmd_flag),
    .cmd_x_i(cmd_x), .cmd_y_i(cmd_y),
    .cell_x_o(cell_x), .cell_y_o(cell_y),
    .board_val_i(board_val), .cover_val_i(cover_val),
    .cover_open_o(cover_open), .cover_flag_o(cover_flag),
    .busy_o(busy), .done_o(done), .game_over_o(game_over),
    .revealed_count_o(revealed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign idx = {cell_y, cell_x};

  // Board and cover arrays: one-cycle read latency, strobes applied at the edge.
  always @(posedge clk) begin
    board_val <= board_mem[idx];
    cover_val <= cover_mem[idx];
    if (cov_clr) begin
      for (int i = 0; i < 256; i++) cover_mem[i] <= 2'b00;
    end else if (cover_open) begin
      cover_mem[idx] <= 2'b10;
    end else if (cover_flag) begin
      cover_mem[idx] <= cover_mem[idx] ^ 2'b01;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_board(input logic [4:0] v);
    for (int i = 0; i < 256; i++) board_mem[i] = v;
  endtask

  task automatic clear_cover();
    @(negedge clk) cov_clr = 1'b1;
    @(negedge clk) cov_clr = 1'b0;
  endtask

  // Returns at the negedge of cycle 1 (accept edge ends cycle 0).
  task automatic issue(input logic f, input int x, input int y);
    @(negedge clk);
    cmd_flag  = f;
    cmd_x     = 4'(x);
    cmd_y     = 4'(y);
    cmd_valid = 1'b1;
    chk("ready_at_issue", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n_open, n_bad, n_done, guard, d_cyc, strobes, ready_seen;
    int oc[8];
    int oi[8];
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_flag = 1'b0; cmd_x = '0; cmd_y = '0;
    cov_clr = 1'b0;
    fill_board(5'd3);
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_revealed", revealed, 0);
    chk("rst_cell", {cell_y, cell_x}, 0);
    chk("rst_strobes", {cover_open, cover_flag}, 0);
    rst_n = 1'b1;
    clear_cover();
    chk("ready_after_rst", cmd_ready, 1);

    // Open a numbered covered cell.
    issue(1'b0, 5, 5);
    chk("num_c1_busy", busy, 1);
    chk("num_c1_cell", {cell_y, cell_x}, 8'h55);
    @(negedge clk);
    chk("num_c2_open", cover_open, 1);
    chk("num_c2_cell", {cell_y, cell_x}, 8'h55);
    chk("num_c2_done", done, 0);
    @(negedge clk);
    chk("num_c3_done", done, 1);
    chk("num_c3_ready", cmd_ready, 0);
    chk("num_c3_open", cover_open, 0);
    @(negedge clk);
    chk("num_c4_ready", cmd_ready, 1);
    chk("num_c4_done", done, 0);
    chk("num_c4_revealed", revealed, 1);

    // Flag a covered cell, then try to open it, then flag an open cell.
    issue(1'b1, 3, 4);
    @(negedge clk);
    chk("flag_c2_strobe", cover_flag, 1);
    chk("flag_c2_done", done, 1);
    @(negedge clk);
    chk("flag_c3_ready", cmd_ready, 1);
    chk("flag_cover_state", cover_mem[8'h43], 2'b01);
    issue(1'b0, 3, 4);
    @(negedge clk);
    chk("open_flagged_c2", cover_open, 0);
    @(negedge clk);
    chk("open_flagged_c3_done", done, 1);
    chk("open_flagged_revealed", revealed, 1);
    issue(1'b1, 5, 5);
    @(negedge clk);
    chk("flag_open_c2_strobe", cover_flag, 0);
    chk("flag_open_c2_done", done, 1);
    @(negedge clk);
    chk("flag_open_c3_ready", cmd_ready, 1);

    // Corner flood: (0,0) is zero, every other cell counts 1.
    clear_cover();
    fill_board(5'd1);
    board_mem[0] = 5'd0;
    n_open = 0; d_cyc = 0;
    issue(1'b0, 0, 0);
    for (int c = 1; c <= 24; c++) begin
      if (cover_open && n_open < 8) begin
        oc[n_open] = c;
        oi[n_open] = int'(idx);
        n_open++;
      end
      if (done && d_cyc == 0) d_cyc = c;
      @(negedge clk);
    end
    chk("corner_opens", n_open, 4);
    chk("corner_done_cyc", d_cyc, 20);
    chk("corner_o0", {oc[0][7:0], oi[0][7:0]}, {8'd2, 8'h00});
    chk("corner_o1", {oc[1][7:0], oi[1][7:0]}, {8'd13, 8'h01});
    chk("corner_o2", {oc[2][7:0], oi[2][7:0]}, {8'd16, 8'h10});
    chk("corner_o3", {oc[3][7:0], oi[3][7:0]}, {8'd19, 8'h11});
    chk("corner_revealed", revealed, 5);

    // Whole mine-free zero board from the middle.
    clear_cover();
    fill_board(5'd0);
    n_open = 0; n_bad = 0; n_done = 0; guard = 0;
    issue(1'b0, 7, 7);
    while (busy && guard < 6000) begin
      if (cover_open) begin
        n_open++;
        if (cover_mem[idx] !== 2'b00) n_bad++;
      end
      if (done) n_done++;
      @(negedge clk);
      guard++;
    end
    chk("flood_no_timeout", guard < 6000, 1);
    chk("flood_opens", n_open, 256);
    chk("flood_dup_opens", n_bad, 0);
    chk("flood_done_pulses", n_done, 1);
    chk("flood_revealed", revealed, 261);
    chk("flood_ready", cmd_ready, 1);
    n_bad = 0;
    for (int i = 0; i < 256; i++) if (cover_mem[i] !== 2'b10) n_bad++;
    chk("flood_all_open", n_bad, 0);

    // Reset during the PUSH phase of a flood.
    clear_cover();
    issue(1'b0, 7, 7);
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_revealed", revealed, 0);
    chk("midrst_cell", {cell_y, cell_x}, 0);
    chk("midrst_outs", {cover_open, cover_flag, done, game_over}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int c = 0; c < 20; c++) begin
      strobes += int'(cover_open) + int'(cover_flag) + int'(done) + int'(busy);
      @(negedge clk);
    end
    chk("midrst_quiet", strobes, 0);
    chk("midrst_ready", cmd_ready, 1);

    // Mine at (2,2).
    clear_cover();
    fill_board(5'd3);
    board_mem[8'h22] = 5'b10000;
    issue(1'b0, 2, 2);
    @(negedge clk);
    chk("mine_c2_open", cover_open, 1);
    chk("mine_c2_game_over", game_over, 1);
    chk("mine_c2_done", done, 1);
    @(negedge clk);
    chk("mine_c3_game_over", game_over, 1);
    chk("mine_c3_done", done, 0);
    chk("mine_c3_busy", busy, 0);
    chk("mine_revealed", revealed, 1);
    cmd_valid = 1'b1; cmd_flag = 1'b0; cmd_x = 4'd9; cmd_y = 4'd9;
    ready_seen = 0;
    for (int c = 0; c < 6; c++) begin
      ready_seen += int'(cmd_ready) + int'(busy);
      @(negedge clk);
    end
    chk("mine_held_off", ready_seen, 0);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mine_rst_game_over", game_over, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mine_rst_ready", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
